// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared types and constants for the RO PUF measurement controller
package ro_puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam int CLEAR_CYC = 2;

  // Cycles from the accepted start cycle to the done pulse.
  function automatic int total_latency(input int n_bits, input int window, input int settle);
    return n_bits * (window + settle + CLEAR_CYC + 1) + 1;
  endfunction

endpackage

// File: rtl/puf_window_timer.sv
// rtl/puf_window_timer.sv - loadable down-counter timing the clear, gate and settle phases
module puf_window_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/ro_puf_measure_ctrl.sv
// rtl/ro_puf_measure_ctrl.sv - sequences RO-pair selection, gating and comparison into a response word
module ro_puf_measure_ctrl
  import ro_puf_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1000,
  parameter int SETTLE = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2*SEL_W-1:0] challenge,
  output logic [SEL_W-1:0]   sel_a,
  output logic [SEL_W-1:0]   sel_b,
  output logic               ro_en,
  output logic               cnt_clr_n,
  input  logic [CNT_W-1:0]   count_a,
  input  logic [CNT_W-1:0]   count_b,
  output logic               busy,
  output logic               done,
  output logic [N_BITS-1:0]  response,
  output logic               tie
);

  localparam int TMR_MAX = (WINDOW > SETTLE)
                         ? ((WINDOW > CLEAR_CYC) ? WINDOW : CLEAR_CYC)
                         : ((SETTLE > CLEAR_CYC) ? SETTLE : CLEAR_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_base_a;
  logic [SEL_W-1:0]   r_base_b;
  logic [SEL_W-1:0]   r_sel_a;
  logic [SEL_W-1:0]   r_sel_b;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_last;
  logic [N_BITS-1:0]  r_response;
  logic               r_tie;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_expired;

  assign w_idx_nxt = r_idx + 1'b1;
  assign w_last    = (r_idx == IDX_W'(N_BITS - 1));

  puf_window_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .expired  (w_tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The timer is loaded on the transition into each timed phase so it reads 0 on that phase's last cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    ro_en       = 1'b0;
    cnt_clr_n   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = S_CLEAR;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(CLEAR_CYC - 1);
        end
      end
      S_CLEAR: begin
        if (w_tmr_expired) begin
          w_state_nxt = S_RUN;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(WINDOW - 1);
        end
      end
      S_RUN: begin
        ro_en     = 1'b1;
        cnt_clr_n = 1'b1;
        if (w_tmr_expired) begin
          w_state_nxt = S_SETTLE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(SETTLE - 1);
        end
      end
      S_SETTLE: begin
        cnt_clr_n = 1'b1;
        if (w_tmr_expired) begin
          w_state_nxt = S_COMPARE;
        end
      end
      S_COMPARE: begin
        cnt_clr_n = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CLEAR;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(CLEAR_CYC - 1);
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Selects move only on the edge entering CLEAR, so they are stable for the whole gate window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base_a   <= '0;
      r_base_b   <= '0;
      r_sel_a    <= '0;
      r_sel_b    <= '0;
      r_idx      <= '0;
      r_response <= '0;
      r_tie      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base_a   <= challenge[2*SEL_W-1:SEL_W];
            r_base_b   <= challenge[SEL_W-1:0];
            r_sel_a    <= challenge[2*SEL_W-1:SEL_W];
            r_sel_b    <= challenge[SEL_W-1:0];
            r_idx      <= '0;
            r_response <= '0;
            r_tie      <= 1'b0;
          end
        end
        S_COMPARE: begin
          r_response[r_idx] <= (count_a > count_b);
          if (count_a == count_b) begin
            r_tie <= 1'b1;
          end
          if (!w_last) begin
            r_idx   <= w_idx_nxt;
            r_sel_a <= r_base_a + SEL_W'(w_idx_nxt);
            r_sel_b <= r_base_b + SEL_W'(w_idx_nxt);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sel_a    = r_sel_a;
  assign sel_b    = r_sel_b;
  assign response = r_response;
  assign tie      = r_tie;

endmodule
